multicycle_controller: RTL and testbench

Sequencing controller for the multicycle ARM datapath. It holds the main instruction FSM, the instruction decoder and the condition/flag logic. Each cycle it drives the datapath's mux selects, ALU operation and write enables, stepping every instruction through fetch, decode, execute and writeback in 2–5 cycles. Instr comes from the datapath's instruction register; ALUFlags comes from the combinational ALU output.

---
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencing controller: main FSM, instruction decode,
// condition check and the NZCV flag register.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      r_state;
    logic [3:0]  r_flags;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic        w_i;
    logic [3:0]  w_cmd;
    logic        w_s;
    logic        w_u;
    logic        w_rd_pc;
    logic        w_unused_bits;

    assign w_cond  = Instr[31:28];
    assign w_op    = Instr[27:26];
    assign w_i     = Instr[25];
    assign w_cmd   = Instr[24:21];
    assign w_s     = Instr[20];
    assign w_u     = Instr[23];
    assign w_rd_pc = (Instr[15:12] == 4'hF);
    assign w_unused_bits = ^{Instr[19:16], Instr[11:0]};

    logic w_add;
    logic w_sub;
    logic w_and;
    logic w_orr;
    logic w_cmp;
    logic w_dp_wb;
    logic w_nz_we;
    logic w_cv_we;

    assign w_add   = (w_cmd == 4'b0100);
    assign w_sub   = (w_cmd == 4'b0010);
    assign w_and   = (w_cmd == 4'b0000);
    assign w_orr   = (w_cmd == 4'b1100);
    assign w_cmp   = (w_cmd == 4'b1010);
    assign w_dp_wb = w_add | w_sub | w_and | w_orr;
    // Logical ops only touch NZ; CV survives them.
    assign w_nz_we = (w_s & w_dp_wb) | w_cmp;
    assign w_cv_we = (w_s & (w_add | w_sub)) | w_cmp;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_cond_ex;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    logic [2:0] w_dp_alu;

    always_comb begin
        w_dp_alu = 3'b000;
        if (w_add)      w_dp_alu = 3'b000;
        else if (w_sub) w_dp_alu = 3'b001;
        else if (w_and) w_dp_alu = 3'b010;
        else if (w_orr) w_dp_alu = 3'b011;
        else if (w_cmp) w_dp_alu = 3'b001;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                FETCH: r_state <= DECODE;
                DECODE: begin
                    if (!w_cond_ex)
                        r_state <= FETCH;
                    else if (w_op == 2'b01)
                        r_state <= MEMADR;
                    else if (w_op == 2'b00)
                        r_state <= w_i ? EXECI : EXECR;
                    else if (w_op == 2'b10)
                        r_state <= BRANCH;
                    else
                        r_state <= FETCH;
                end
                MEMADR: r_state <= w_s ? MEMRD : MEMWR;
                MEMRD:  r_state <= MEMWB;
                MEMWB:  r_state <= FETCH;
                MEMWR:  r_state <= FETCH;
                EXECR, EXECI: begin
                    if (w_nz_we) r_flags[3:2] <= ALUFlags[3:2];
                    if (w_cv_we) r_flags[1:0] <= ALUFlags[1:0];
                    r_state <= w_dp_wb ? ALUWB : FETCH;
                end
                ALUWB:  r_state <= FETCH;
                BRANCH: r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    logic w_pc_we;
    logic w_mem_we;
    logic w_reg_we;
    logic w_ir_we;

    always_comb begin
        w_pc_we    = 1'b0;
        w_mem_we   = 1'b0;
        w_reg_we   = 1'b0;
        w_ir_we    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        case (r_state)
            FETCH: begin
                w_ir_we   = 1'b1;
                w_pc_we   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_u ? 3'b000 : 3'b001;
            end
            MEMRD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                w_reg_we  = 1'b1;
                w_pc_we   = w_rd_pc;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                w_mem_we = 1'b1;
            end
            EXECR: ALUControl = w_dp_alu;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dp_alu;
            end
            ALUWB: begin
                w_reg_we = 1'b1;
                w_pc_we  = w_rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pc_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = w_pc_we  & ~reset;
    assign MemWrite = w_mem_we & ~reset;
    assign RegWrite = w_reg_we & ~reset;
    assign IRWrite  = w_ir_we  & ~reset;
    assign RegSrc   = {w_op == 2'b01, w_op == 2'b10};
    assign ImmSrc   = w_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors
// are queued from a spec-derived table and compared each cycle.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        S_F, S_D, S_MA, S_MR, S_MB, S_MW, S_ER, S_EI, S_AW, S_BR
    } st_t;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] regsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [2:0] alu;
    } ov_t;

    ov_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  n_ins  = 0;

    function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'b000;
            4'b0010: return 3'b001;
            4'b0000: return 3'b010;
            4'b1100: return 3'b011;
            4'b1010: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ov_t exp_out(input st_t s, input logic [31:0] ins,
                                    input logic rst);
        ov_t e;
        logic [1:0] op;
        logic rdpc;
        op = ins[27:26];
        rdpc = (ins[15:12] == 4'hF);
        e = '0;
        e.regsrc = {op == 2'b01, op == 2'b10};
        e.imm = op;
        case (s)
            S_F: begin
                e.irw = 1; e.srca = 1; e.srcb = 2'b10;
                e.res = 2'b10; e.pcw = 1;
            end
            S_D: begin e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; end
            S_MA: begin
                e.srcb = 2'b01;
                e.alu = ins[23] ? 3'b000 : 3'b001;
            end
            S_MR: e.adr = 1;
            S_MB: begin e.res = 2'b01; e.regw = 1; e.pcw = rdpc; end
            S_MW: begin e.adr = 1; e.memw = 1; end
            S_ER: e.alu = cmd_alu(ins[24:21]);
            S_EI: begin e.srcb = 2'b01; e.alu = cmd_alu(ins[24:21]); end
            S_AW: begin e.res = 2'b00; e.regw = 1; e.pcw = rdpc; end
            S_BR: begin
                e.srcb = 2'b01; e.res = 2'b10; e.pcw = 1;
            end
            default: ;
        endcase
        if (rst) begin
            e.pcw = 0; e.memw = 0; e.regw = 0; e.irw = 0;
        end
        return e;
    endfunction

    task automatic check(input string tag);
        ov_t obs;
        ov_t exp;
        obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            exp = sb.pop_front();
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
            end
        end
    endtask

    // Called aligned to a negedge; leaves aligned to the next free negedge.
    task automatic run(input string nm, input logic [31:0] ins,
                       input logic [3:0] af, input int n,
                       input st_t s0, input st_t s1, input st_t s2,
                       input st_t s3, input st_t s4);
        st_t s[5];
        s = '{s0, s1, s2, s3, s4};
        Instr = ins;
        ALUFlags = af;
        n_ins++;
        for (int i = 0; i < n; i++) sb.push_back(exp_out(s[i], ins, 1'b0));
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s#%0d_c%0d", nm, n_ins, i));
            @(negedge clk);
        end
    endtask

    task automatic br(input string nm, input logic [31:0] ins, input logic tk);
        if (tk) run(nm, ins, 4'h0, 3, S_F, S_D, S_BR, S_F, S_F);
        else    run(nm, ins, 4'h0, 2, S_F, S_D, S_F, S_F, S_F);
    endtask

    initial begin
        reset = 1'b1;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        @(negedge clk);
        sb.push_back(exp_out(S_F, Instr, 1'b1));
        #1 check("reset_fetch");
        @(negedge clk);
        reset = 1'b0;

        run("add_imm", 32'hE2821005, 4'hF, 4, S_F, S_D, S_EI, S_AW, S_F);
        br("beq_z0", 32'h0AFFFFFE, 1'b0);
        br("bcs_c0", 32'h2AFFFFFE, 1'b0);
        run("cmp", 32'hE1510001, 4'b0110, 3, S_F, S_D, S_ER, S_F, S_F);
        br("bne", 32'h1AFFFFFE, 1'b0);
        br("beq", 32'h0AFFFFFE, 1'b1);
        br("bhi", 32'h8AFFFFFE, 1'b0);
        br("bls", 32'h9AFFFFFE, 1'b1);
        run("ldr", 32'hE5910004, 4'h0, 5, S_F, S_D, S_MA, S_MR, S_MB);
        run("str", 32'hE5810004, 4'h0, 4, S_F, S_D, S_MA, S_MW, S_F);
        run("ldr_pc_sub", 32'hE511F004, 4'h0, 5,
            S_F, S_D, S_MA, S_MR, S_MB);
        run("eors_unsup", 32'hE0311002, 4'b1001, 3,
            S_F, S_D, S_ER, S_F, S_F);
        br("beq_held", 32'h0AFFFFFE, 1'b1);
        run("orr_pc", 32'hE18FF002, 4'h0, 4, S_F, S_D, S_ER, S_AW, S_F);
        run("op11", 32'hEC000000, 4'h0, 2, S_F, S_D, S_F, S_F, S_F);
        br("cond_nv", 32'hFAFFFFFE, 1'b0);

        run("str_rst", 32'hE5810004, 4'h0, 3, S_F, S_D, S_MA, S_F, S_F);
        reset = 1'b1;
        sb.push_back(exp_out(S_MW, Instr, 1'b1));
        #1 check("str_memwr_in_reset");
        @(negedge clk);
        reset = 1'b0;
        br("beq_after_rst", 32'h0AFFFFFE, 1'b0);

        run("ands", 32'hE2111000, 4'b1011, 4, S_F, S_D, S_EI, S_AW, S_F);
        br("bmi", 32'h4AFFFFFE, 1'b1);
        br("beq_n", 32'h0AFFFFFE, 1'b0);
        br("bcs_held", 32'h2AFFFFFE, 1'b0);
        br("bvs_held", 32'h6AFFFFFE, 1'b0);
        br("bge", 32'hAAFFFFFE, 1'b0);
        br("blt", 32'hBAFFFFFE, 1'b1);
        br("bgt", 32'hCAFFFFFE, 1'b0);
        br("ble", 32'hDAFFFFFE, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
